// File: rtl/mem_pkg.sv
// mem_pkg: collision-mode constants and address-width helper shared by the read pipeline
package mem_pkg;
    localparam bit READ_FIRST  = 1'b0;
    localparam bit WRITE_FIRST = 1'b1;
    function automatic int addr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/mem_rd_pipe_if.sv
// mem_rd_pipe_if: write port plus read request/response handshakes of the memory
interface mem_rd_pipe_if import mem_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int AW = addr_w(DEPTH);
    logic             wen;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic             rreq_valid;
    logic             rreq_ready;
    logic [AW-1:0]    raddr;
    logic             rresp_valid;
    logic             rresp_ready;
    logic [WIDTH-1:0] rdata;
    modport master (
        output wen, waddr, wdata, rreq_valid, raddr, rresp_ready,
        input  rreq_ready, rresp_valid, rdata
    );
    modport slave (
        input  wen, waddr, wdata, rreq_valid, raddr, rresp_ready,
        output rreq_ready, rresp_valid, rdata
    );
endinterface

// File: rtl/mem_rd_stage.sv
// mem_rd_stage: one enable-gated valid+data register of the read pipeline
module mem_rd_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
endmodule

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: register-array memory with a stallable READ_LATENCY-deep read response pipeline
module mem_rd_pipe #(
    parameter int                     WIDTH        = 16,
    parameter int                     DEPTH        = 16,
    parameter int                     HAS_INIT     = 0,
    parameter logic [WIDTH*DEPTH-1:0] INIT         = '0,
    parameter int                     READ_LATENCY = 1,
    parameter int                     WRITE_FIRST  = 1
) (
    input logic          clk,
    input logic          arst_n,
    mem_rd_pipe_if.slave bus
);
    localparam bit NEW_DATA = WRITE_FIRST == int'(mem_pkg::WRITE_FIRST);
    typedef logic [WIDTH-1:0] mem_t [DEPTH];
    function automatic mem_t preload();
        mem_t m;
        for (int j = 0; j < DEPTH; j++) m[j] = (HAS_INIT != 0) ? INIT[j*WIDTH +: WIDTH] : '0;
        return m;
    endfunction
    mem_t             mem = preload();
    logic             stall;
    logic             v [READ_LATENCY+1];
    logic [WIDTH-1:0] d [READ_LATENCY+1];
    assign stall          = bus.rresp_valid && !bus.rresp_ready;
    assign bus.rreq_ready = !stall;
    assign v[0]           = bus.rreq_valid && !stall;
    assign d[0]           = (NEW_DATA && bus.wen && bus.waddr == bus.raddr) ? bus.wdata : mem[bus.raddr];
    assign bus.rresp_valid = v[READ_LATENCY];
    assign bus.rdata       = d[READ_LATENCY];
    // writes never wait on the read side, but are dropped while reset is held
    always @(posedge clk)
        if (bus.wen && arst_n) mem[bus.waddr] <= bus.wdata;
    for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
        mem_rd_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .arst_n   (arst_n),
            .en       (!stall),
            .in_valid (v[i]),
            .in_data  (d[i]),
            .out_valid(v[i+1]),
            .out_data (d[i+1])
        );
    end
endmodule

// File: doc/mem_rd_pipe.md
MEM_RD_PIPE -- requirements
Module: mem_rd_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of words (power of two, 2..1024); AW = clog2(DEPTH).
REQ-003 SHALL have parameter HAS_INIT, default 0, when 1 preload array from INIT at elaboration.
REQ-004 SHALL have parameter INIT, default 0, WIDTH*DEPTH bits, word j at bits [(j+1)*WIDTH-1 : j*WIDTH].
REQ-005 SHALL have parameter READ_LATENCY, default 1, cycles from accepted request to rresp_valid (legal: 1 or 2).
REQ-006 SHALL have parameter WRITE_FIRST, default 1, same-address collision mode (1 = new data, 0 = old data).
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 wen  input  1  write enable.
REQ-010 waddr  input  AW  write address.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 rreq_valid  input  1  read request valid.
REQ-013 rreq_ready  output  1  read request accepted when high with rreq_valid.
REQ-014 raddr  input  AW  read address, sampled on acceptance.
REQ-015 rresp_valid  output  1  read data valid.
REQ-016 rresp_ready  input  1  consumer accepts rdata.
REQ-017 rdata  output  WIDTH  read data, stable while rresp_valid && !rresp_ready.

Function
REQ-018 Writes SHALL commit on any rising edge with wen=1, independent of read-side stall.
REQ-019 Read request accepted iff rreq_valid && rreq_ready; array read occurs in the acceptance cycle.
REQ-020 stall = rresp_valid && !rresp_ready; rreq_ready SHALL equal !stall (combinational, no dependence on rreq_valid).
REQ-021 Pipeline: READ_LATENCY register stages, each valid+data; all stages advance together when !stall, all hold when stall.
REQ-022 Accepted read at edge N SHALL present rresp_valid at edge N+READ_LATENCY-1 output, i.e. visible READ_LATENCY cycles after acceptance absent stall.
REQ-023 Bubbles (no acceptance while !stall) SHALL propagate as valid=0; no reordering, no drop, no duplication.
REQ-024 Full throughput: one read per cycle sustained while rresp_ready=1.
REQ-025 Collision (accepted read and wen, raddr==waddr, same cycle): WRITE_FIRST=1 returns wdata; WRITE_FIRST=0 returns prior content.
REQ-026 Data captured into a stage SHALL NOT change on later writes to that address, including during stall.
REQ-027 Unwritten, uninitialised words: HAS_INIT=1 returns INIT word; HAS_INIT=0 value unspecified (bench must not check).
REQ-028 Address wrap: AW bits only, DEPTH power of two, no out-of-range case.

Reset
REQ-029 arst_n low SHALL immediately clear all stage valids; rresp_valid=0, rdata=0, rreq_ready=1 during and after reset.
REQ-030 In-flight reads at reset SHALL be discarded; no response emitted after release.
REQ-031 Array contents SHALL NOT be reset; writes with arst_n low SHALL be ignored.
REQ-032 First request SHALL be accepted on the first rising edge after arst_n deasserts.

Structure
REQ-033 Shared package mem_pkg SHALL hold the collision-mode constants (WRITE_FIRST/READ_FIRST) and the address-width helper function.
REQ-034 One sub-module mem_rd_stage (enable-gated valid+data register, async active-low clear) SHALL be instantiated READ_LATENCY times.
REQ-035 Array SHALL be a single reg array of DEPTH x WIDTH; no vendor primitives.

Verification
REQ-036 HAS_INIT=1, WIDTH=5, DEPTH=4, INIT words {5,0,21,11} at addr 0..3, latency 1: read 0,1,2,3 back-to-back, rresp_ready=1 -> rdata 5,0,21,11 on consecutive cycles, no gaps.
REQ-037 Latency 2: write addr 3=0xABCD, then read addr 3 -> rresp_valid exactly 2 cycles after acceptance, rdata=0xABCD.
REQ-038 Collision addr 7, old 0x1111, wdata 0x2222: WRITE_FIRST=1 -> 0x2222; WRITE_FIRST=0 -> 0x1111.
REQ-039 Stall: rresp_ready=0 for 3 cycles with reads pending and a write of 0xFFFF to the held address -> rreq_ready=0, rdata unchanged, responses resume in order once rresp_ready=1.
REQ-040 Reset mid-operation: 2 reads in flight (latency 2), pulse arst_n low between edges -> rresp_valid drops at once, no response after release, memory retains prior writes.
